// File: rtl/writeback_buffer.sv
// writeback_buffer
//   Circular writeback FIFO between the execute/memory stages and the
//   register file, with optional operand forwarding from pending entries.
//
//   Optional feature: define WB_FORWARD_EN to build the forwarding search.
//   Without it, oFwdHit1/2 and oFwdVal1/2 are tied to 0 and no compare
//   logic is built.
//
//   reg_transport_t is carried as a packed vector laid out {addr, value}:
//     [addr_width+reg_width-1 : reg_width]  destination register index
//     [reg_width-1 : 0]                     result value
//
// Ports
//   iClk               single clock, all state updates on its rising edge
//   iRst               synchronous active-high reset
//   iValid / oReady    upstream writeback handshake
//   iWb                upstream {addr, value}
//   iHold              inhibits draining this cycle
//   oWriteEn / oRd     register-file write enable and {addr, value}
//   iAddrRs1/2         forwarding lookup addresses
//   oFwdHit1/2         a pending entry matches the lookup address
//   oFwdVal1/2         value of the youngest matching pending entry
//   oCount             number of pending entries
module writeback_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned reg_width  = 32,
  parameter int unsigned addr_width = 5
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iValid,
  output logic                            oReady,
  input  logic [addr_width+reg_width-1:0] iWb,
  input  logic                            iHold,
  output logic                            oWriteEn,
  output logic [addr_width+reg_width-1:0] oRd,
  input  logic [addr_width-1:0]           iAddrRs1,
  input  logic [addr_width-1:0]           iAddrRs2,
  output logic                            oFwdHit1,
  output logic                            oFwdHit2,
  output logic [reg_width-1:0]            oFwdVal1,
  output logic [reg_width-1:0]            oFwdVal2,
  output logic [$clog2(DEPTH):0]          oCount
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [addr_width-1:0] addr_q [DEPTH];
  logic [reg_width-1:0]  val_q  [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;

  logic [addr_width-1:0] wb_addr;
  logic [reg_width-1:0]  wb_val;
  logic                  not_empty;
  logic                  ready;
  logic                  push;
  logic                  pop;

  assign wb_addr   = iWb[reg_width +: addr_width];
  assign wb_val    = iWb[reg_width-1:0];
  assign not_empty = (count != '0);

  // A full buffer refuses requests even in a cycle where it drains.
  // Reset forces the idle-side view of the outputs immediately.
  assign ready    = (count < CW'(DEPTH)) | iRst;
  assign oReady   = ready;
  assign oWriteEn = not_empty & ~iHold & ~iRst;
  assign oCount   = count;
  assign oRd      = (not_empty && !iRst) ? {addr_q[head], val_q[head]} : '0;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign push = iValid & ready & ~iRst & (wb_addr != '0);
  assign pop  = oWriteEn;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= wb_addr;
        val_q[tail]  <= wb_val;
        tail         <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic                 hit1;
  logic                 hit2;
  logic [reg_width-1:0] val1;
  logic [reg_width-1:0] val2;

  // Walk from oldest to youngest so a later match overwrites an earlier one.
  // The head is included even when it is being drained this cycle; the
  // incoming iWb is not in storage yet and so is never seen.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    val1 = '0;
    val2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (addr_q[head + PW'(k)] == iAddrRs1) begin
          hit1 = 1'b1;
          val1 = val_q[head + PW'(k)];
        end
        if (addr_q[head + PW'(k)] == iAddrRs2) begin
          hit2 = 1'b1;
          val2 = val_q[head + PW'(k)];
        end
      end
    end
    if (iAddrRs1 == '0 || iRst) begin
      hit1 = 1'b0;
      val1 = '0;
    end
    if (iAddrRs2 == '0 || iRst) begin
      hit2 = 1'b0;
      val2 = '0;
    end
  end

  assign oFwdHit1 = hit1;
  assign oFwdHit2 = hit2;
  assign oFwdVal1 = val1;
  assign oFwdVal2 = val2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{iAddrRs1, iAddrRs2};

  assign oFwdHit1 = 1'b0;
  assign oFwdHit2 = 1'b0;
  assign oFwdVal1 = '0;
  assign oFwdVal2 = '0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [36:0] iWb;
  logic        iHold;
  logic        oWriteEn;
  logic [36:0] oRd;
  logic [4:0]  iAddrRs1;
  logic [4:0]  iAddrRs2;
  logic        oFwdHit1;
  logic        oFwdHit2;
  logic [31:0] oFwdVal1;
  logic [31:0] oFwdVal2;
  logic [2:0]  oCount;

  int checks = 0;
  int errors = 0;

  writeback_buffer #(.DEPTH(4), .reg_width(32), .addr_width(5)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iWb(iWb),
    .iHold(iHold), .oWriteEn(oWriteEn), .oRd(oRd),
    .iAddrRs1(iAddrRs1), .iAddrRs2(iAddrRs2),
    .oFwdHit1(oFwdHit1), .oFwdHit2(oFwdHit2),
    .oFwdVal1(oFwdVal1), .oFwdVal2(oFwdVal2), .oCount(oCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Advance past one rising edge; inputs are then changed away from the edge.
  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iHold = 1'b0; iValid = 1'b1; iWb = {5'd3, 32'h0000_0333};
    cyc(); cyc();
    #2;
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", oReady); end
    checks++; if (oWriteEn !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", oWriteEn); end
    checks++; if (oRd !== 37'd0) begin errors++; $display("FAIL rst_rd: got %h expected 0", oRd); end
    checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", oCount); end
    checks++; if (oFwdHit1 !== 1'b0 || oFwdHit2 !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b%b expected 00", oFwdHit1, oFwdHit2); end
    checks++; if (oFwdVal1 !== 32'd0 || oFwdVal2 !== 32'd0) begin errors++; $display("FAIL rst_fval: got %h %h expected 0 0", oFwdVal1, oFwdVal2); end
    iRst = 1'b0; iValid = 1'b0;
    cyc();
    #2;
    checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL rst_req_ignored: got %0d expected 0", oCount); end
  endtask

  task automatic test_single();
    iHold = 1'b0; iValid = 1'b1; iWb = {5'd5, 32'hDEAD_BEEF};
    #2;
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", oReady); end
    cyc();
    iValid = 1'b0;
    #2;
    checks++; if (oWriteEn !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", oWriteEn); end
    checks++; if (oRd !== {5'd5, 32'hDEAD_BEEF}) begin errors++; $display("FAIL single_rd: got %h expected %h", oRd, {5'd5, 32'hDEAD_BEEF}); end
    cyc();
    #2;
    checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", oCount); end
    checks++; if (oWriteEn !== 1'b0) begin errors++; $display("FAIL single_we_after: got %b expected 0", oWriteEn); end
  endtask

  task automatic test_fill_hold();
    logic [36:0] exp_rd;
    iHold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      iValid = 1'b1; iWb = {5'(i), 32'(32'h11 * i)};
      cyc();
    end
    iValid = 1'b0;
    #2;
    checks++; if (oCount !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", oCount); end
    checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", oReady); end
    checks++; if (oWriteEn !== 1'b0) begin errors++; $display("FAIL fill_we_hold: got %b expected 0", oWriteEn); end
    iAddrRs1 = 5'd2;
    #1;
    checks++; if (oFwdHit1 !== FWD || oFwdVal1 !== (FWD ? 32'h22 : 32'h0)) begin errors++; $display("FAIL fill_fwd: got %b %h expected %b %h", oFwdHit1, oFwdVal1, FWD, FWD ? 32'h22 : 32'h0); end
    iAddrRs1 = 5'd0;
    iValid = 1'b1; iWb = {5'd9, 32'h99};
    cyc();
    iValid = 1'b0;
    #2;
    checks++; if (oCount !== 3'd4) begin errors++; $display("FAIL fill_fifth_rejected: got %0d expected 4", oCount); end
    iHold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #2;
      exp_rd = {5'(i), 32'(32'h11 * i)};
      checks++; if (oWriteEn !== 1'b1 || oRd !== exp_rd) begin errors++; $display("FAIL fill_drain_%0d: got we=%b rd=%h expected we=1 rd=%h", i, oWriteEn, oRd, exp_rd); end
      cyc();
    end
    #2;
    checks++; if (oCount !== 3'd0 || oWriteEn !== 1'b0) begin errors++; $display("FAIL fill_empty: got count=%0d we=%b expected 0 0", oCount, oWriteEn); end
  endtask

  task automatic test_zero_addr();
    iHold = 1'b0; iValid = 1'b1; iWb = {5'd0, 32'h1234};
    #2;
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", oReady); end
    cyc();
    iValid = 1'b0;
    #2;
    checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", oCount); end
    checks++; if (oWriteEn !== 1'b0) begin errors++; $display("FAIL zero_we: got %b expected 0", oWriteEn); end
  endtask

  task automatic test_forward();
    iHold = 1'b1;
    iValid = 1'b1; iWb = {5'd7, 32'hA}; cyc();
    iWb = {5'd7, 32'hB}; cyc();
    iWb = {5'd3, 32'hC}; cyc();
    // Same-cycle incoming write to x7 must not be visible yet.
    iWb = {5'd7, 32'hF};
    iAddrRs1 = 5'd7; iAddrRs2 = 5'd0;
    #2;
    checks++; if (oFwdHit1 !== FWD || oFwdVal1 !== (FWD ? 32'hB : 32'h0)) begin errors++; $display("FAIL fwd_youngest: got %b %h expected %b %h", oFwdHit1, oFwdVal1, FWD, FWD ? 32'hB : 32'h0); end
    checks++; if (oFwdHit2 !== 1'b0 || oFwdVal2 !== 32'h0) begin errors++; $display("FAIL fwd_r0: got %b %h expected 0 0", oFwdHit2, oFwdVal2); end
    cyc();
    iValid = 1'b0; iAddrRs2 = 5'd3;
    #2;
    checks++; if (oFwdHit1 !== FWD || oFwdVal1 !== (FWD ? 32'hF : 32'h0)) begin errors++; $display("FAIL fwd_after_push: got %b %h expected %b %h", oFwdHit1, oFwdVal1, FWD, FWD ? 32'hF : 32'h0); end
    checks++; if (oFwdHit2 !== FWD || oFwdVal2 !== (FWD ? 32'hC : 32'h0)) begin errors++; $display("FAIL fwd_rs2: got %b %h expected %b %h", oFwdHit2, oFwdVal2, FWD, FWD ? 32'hC : 32'h0); end
    iHold = 1'b0;
    cyc(); cyc(); cyc();
    #2;
    checks++; if (oWriteEn !== 1'b1 || oFwdHit1 !== FWD || oFwdVal1 !== (FWD ? 32'hF : 32'h0)) begin errors++; $display("FAIL fwd_head_draining: got we=%b %b %h expected we=1 %b %h", oWriteEn, oFwdHit1, oFwdVal1, FWD, FWD ? 32'hF : 32'h0); end
    checks++; if (oFwdHit2 !== 1'b0) begin errors++; $display("FAIL fwd_rs2_drained: got %b expected 0", oFwdHit2); end
    cyc();
    #2;
    checks++; if (oCount !== 3'd0 || oFwdHit1 !== 1'b0) begin errors++; $display("FAIL fwd_empty: got count=%0d hit=%b expected 0 0", oCount, oFwdHit1); end
    iAddrRs1 = 5'd0; iAddrRs2 = 5'd0;
  endtask

  task automatic test_back_to_back();
    int next_push;
    int exp_cnt;
    logic exp_ready;
    logic [36:0] exp_rd;
    iHold = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      iValid = 1'b1; iWb = {5'(i), 32'(32'h100 + i)};
      cyc();
    end
    iHold = 1'b0;
    next_push = 15;
    exp_cnt = 4;
    for (int j = 0; j < 8; j++) begin
      iValid = (next_push <= 18);
      iWb = {5'(next_push), 32'(32'h100 + next_push)};
      #2;
      exp_ready = (exp_cnt < 4);
      exp_rd = {5'(11 + j), 32'(32'h100 + 11 + j)};
      checks++; if (oReady !== exp_ready) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected %b", j, oReady, exp_ready); end
      checks++; if (oWriteEn !== 1'b1 || oRd !== exp_rd) begin errors++; $display("FAIL b2b_drain_%0d: got we=%b rd=%h expected we=1 rd=%h", j, oWriteEn, oRd, exp_rd); end
      if (iValid && exp_ready) next_push++;
      else exp_cnt--;
      cyc();
      #2;
      checks++; if (oCount !== 3'(exp_cnt)) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected %0d", j, oCount, exp_cnt); end
    end
    iValid = 1'b0;
  endtask

  task automatic test_reset_mid();
    iHold = 1'b1;
    for (int i = 21; i <= 23; i++) begin
      iValid = 1'b1; iWb = {5'(i), 32'(32'h200 + i)};
      cyc();
    end
    iValid = 1'b0;
    iHold = 1'b0; iRst = 1'b1; iAddrRs1 = 5'd22;
    #2;
    checks++; if (oWriteEn !== 1'b0 || oRd !== 37'd0) begin errors++; $display("FAIL rmid_during: got we=%b rd=%h expected 0 0", oWriteEn, oRd); end
    checks++; if (oReady !== 1'b1 || oFwdHit1 !== 1'b0 || oFwdVal1 !== 32'd0) begin errors++; $display("FAIL rmid_during_rdy_fwd: got rdy=%b hit=%b val=%h expected 1 0 0", oReady, oFwdHit1, oFwdVal1); end
    cyc();
    iRst = 1'b0;
    #2;
    checks++; if (oCount !== 3'd0 || oWriteEn !== 1'b0 || oReady !== 1'b1) begin errors++; $display("FAIL rmid_after: got count=%0d we=%b rdy=%b expected 0 0 1", oCount, oWriteEn, oReady); end
    for (int j = 0; j < 3; j++) begin
      cyc();
      #2;
      checks++; if (oWriteEn !== 1'b0 || oRd !== 37'd0 || oFwdHit1 !== 1'b0) begin errors++; $display("FAIL rmid_stale_%0d: got we=%b rd=%h hit=%b expected 0 0 0", j, oWriteEn, oRd, oFwdHit1); end
    end
    iAddrRs1 = 5'd0;
  endtask

  initial begin
    iRst = 1'b1; iValid = 1'b0; iWb = '0; iHold = 1'b0;
    iAddrRs1 = '0; iAddrRs2 = '0;
    test_reset();
    test_single();
    test_fill_hold();
    test_zero_addr();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
